// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scancode stream to per-key held state with press/release pulses.
// Handles E0/F0 prefixes, typematic repeat, the E1 Pause sequence and error bytes.
module ps2_key_tracker #(
    parameter int                  N_KEYS    = 4,
    parameter logic [N_KEYS*9-1:0] KEY_CODES = {9'h172, 9'h175, 9'h01B, 9'h01D},
    parameter int                  TIMEOUT   = 50000
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic [7:0]        kb_data,
    input  logic              kb_valid,
    output logic [N_KEYS-1:0] key_held,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              kb_error
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    state_t            state;
    logic [TW-1:0]     tmo_cnt;
    logic [2:0]        skip_cnt;
    logic              ext;
    logic [8:0]        code;
    logic [N_KEYS-1:0] match;
    logic              is_err;

    // The extended bit comes from the prefix state, not from the byte.
    always_comb begin
        ext    = (state == EXT) || (state == EXT_BRK);
        code   = {ext, kb_data};
        is_err = (kb_data == 8'h00) || (kb_data == 8'hFF) ||
                 (kb_data == 8'hFE) || (kb_data == 8'hAA);
        match  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            match[i] = (KEY_CODES[9*i +: 9] == code);
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            skip_cnt    <= '0;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            kb_error    <= 1'b0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            kb_error    <= 1'b0;
            if (kb_valid) begin
                tmo_cnt <= '0;
                if (state == SKIP) begin
                    if (skip_cnt <= 3'd1) begin
                        skip_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        skip_cnt <= skip_cnt - 3'd1;
                    end
                end else if (is_err) begin
                    key_held <= '0;
                    kb_error <= 1'b1;
                    state    <= IDLE;
                end else begin
                    case (state)
                        IDLE: begin
                            if (kb_data == 8'hE0) begin
                                state <= EXT;
                            end else if (kb_data == 8'hF0) begin
                                state <= BRK;
                            end else if (kb_data == 8'hE1) begin
                                state    <= SKIP;
                                skip_cnt <= 3'd7;
                            end else begin
                                key_press <= match & ~key_held;
                                key_held  <= key_held | match;
                            end
                        end
                        EXT: begin
                            if (kb_data == 8'hF0) begin
                                state <= EXT_BRK;
                            end else if (kb_data == 8'hE0) begin
                                state <= EXT;
                            end else begin
                                key_press <= match & ~key_held;
                                key_held  <= key_held | match;
                                state     <= IDLE;
                            end
                        end
                        BRK, EXT_BRK: begin
                            key_release <= match & key_held;
                            key_held    <= key_held & ~match;
                            state       <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end else if (state != IDLE) begin
                // A stalled prefix is dropped so a lost byte cannot wedge decoding.
                if (tmo_cnt == TMO_MAX) begin
                    tmo_cnt  <= '0;
                    skip_cnt <= '0;
                    state    <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed testbench for ps2_key_tracker: scancode sequences with
// hand-computed held state and pulse expectations.
module tb_ps2_key_tracker;

    localparam int T = 16;

    logic       clk50 = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_valid = 1'b0;
    logic [3:0] key_held;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       kb_error;

    int checks = 0;
    int errors = 0;

    ps2_key_tracker #(
        .N_KEYS (4),
        .TIMEOUT(T)
    ) dut (
        .clk50      (clk50),
        .reset      (reset),
        .kb_data    (kb_data),
        .kb_valid   (kb_valid),
        .key_held   (key_held),
        .key_press  (key_press),
        .key_release(key_release),
        .kb_error   (kb_error)
    );

    always #5 clk50 = ~clk50;

    // Called at a negedge; returns at the next negedge with the byte sampled.
    task automatic send(input logic [7:0] b);
        kb_data  = b;
        kb_valid = 1'b1;
        @(negedge clk50);
        kb_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk50);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk50);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (key_held !== 4'b0000) begin
            errors++;
            $display("FAIL reset_held got %b exp 0000", key_held);
        end
        checks++;
        if ({key_press, key_release, kb_error} !== 9'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b exp 0", {key_press, key_release, kb_error});
        end
    endtask

    task automatic test_make_break();
        send(8'h1D);
        checks++;
        if ({key_press, key_held} !== 8'b0001_0001) begin
            errors++;
            $display("FAIL make_w got press/held %b exp 00010001", {key_press, key_held});
        end
        idle(1);
        checks++;
        if (key_press !== 4'b0000) begin
            errors++;
            $display("FAIL make_w_pulse_len got %b exp 0000", key_press);
        end
        send(8'hF0);
        send(8'h1D);
        checks++;
        if ({key_release, key_held} !== 8'b0001_0000) begin
            errors++;
            $display("FAIL break_w got rel/held %b exp 00010000", {key_release, key_held});
        end
        idle(1);
        checks++;
        if (key_release !== 4'b0000) begin
            errors++;
            $display("FAIL break_w_pulse_len got %b exp 0000", key_release);
        end
    endtask

    task automatic test_typematic();
        send(8'h1D);
        checks++;
        if (key_press !== 4'b0001) begin
            errors++;
            $display("FAIL typ_first got %b exp 0001", key_press);
        end
        send(8'h1D);
        send(8'h1D);
        checks++;
        if ({key_press, key_held} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL typ_repeat got press/held %b exp 00000001", {key_press, key_held});
        end
        send(8'hE0);
        send(8'h75);
        checks++;
        if ({key_press, key_held} !== 8'b0100_0101) begin
            errors++;
            $display("FAIL make_up got press/held %b exp 01000101", {key_press, key_held});
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        checks++;
        if ({key_release, key_held} !== 8'b0100_0001) begin
            errors++;
            $display("FAIL break_up got rel/held %b exp 01000001", {key_release, key_held});
        end
    endtask

    task automatic test_unmatched();
        send(8'h75);
        checks++;
        if ({key_press, key_release, key_held} !== 12'b0000_0000_0001) begin
            errors++;
            $display("FAIL plain_75 got %b exp 000000000001", {key_press, key_release, key_held});
        end
        send(8'hF0);
        send(8'h72);
        checks++;
        if ({key_press, key_release, key_held} !== 12'b0000_0000_0001) begin
            errors++;
            $display("FAIL plain_brk_72 got %b exp 000000000001", {key_press, key_release, key_held});
        end
        send(8'hF0);
        send(8'h1D);
        checks++;
        if (key_held !== 4'b0000) begin
            errors++;
            $display("FAIL unmatched_cleanup got %b exp 0000", key_held);
        end
    endtask

    task automatic test_error();
        send(8'h1D);
        send(8'hE0);
        send(8'h72);
        checks++;
        if (key_held !== 4'b1001) begin
            errors++;
            $display("FAIL err_setup got %b exp 1001", key_held);
        end
        send(8'hAA);
        checks++;
        if ({kb_error, key_release, key_press, key_held} !== 13'b1_0000_0000_0000) begin
            errors++;
            $display("FAIL err_aa got %b exp 1000000000000",
                     {kb_error, key_release, key_press, key_held});
        end
        idle(1);
        checks++;
        if (kb_error !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_len got %b exp 0", kb_error);
        end
        // Error byte after E0 must win over prefix decoding and return to IDLE.
        send(8'hE0);
        send(8'hFF);
        checks++;
        if (kb_error !== 1'b1) begin
            errors++;
            $display("FAIL err_ff_ext got %b exp 1", kb_error);
        end
        send(8'h1D);
        checks++;
        if ({key_press, key_held} !== 8'b0001_0001) begin
            errors++;
            $display("FAIL err_then_make got %b exp 00010001", {key_press, key_held});
        end
        send(8'hF0);
        send(8'h1D);
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [8:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            send(seq[i]);
            acc |= {key_press, key_release, kb_error};
        end
        checks++;
        if (acc !== 9'b0) begin
            errors++;
            $display("FAIL pause_pulses got %b exp 0", acc);
        end
        send(8'h1B);
        checks++;
        if ({key_press, key_held} !== 8'b0010_0010) begin
            errors++;
            $display("FAIL pause_then_s got %b exp 00100010", {key_press, key_held});
        end
        send(8'hF0);
        send(8'h1B);
        // Seventh skipped byte is a tracked code and an error byte sits inside.
        seq = '{8'hE1, 8'hAA, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h1D};
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            send(seq[i]);
            acc |= {key_press, key_release, kb_error};
        end
        checks++;
        if ({acc, key_held} !== 13'b0) begin
            errors++;
            $display("FAIL pause_len got %b exp 0", {acc, key_held});
        end
    endtask

    task automatic test_timeout();
        send(8'hE0);
        idle(T);
        send(8'h72);
        checks++;
        if ({key_press, key_held} !== 8'b0000_0000) begin
            errors++;
            $display("FAIL tmo_expired got %b exp 00000000", {key_press, key_held});
        end
        send(8'hE0);
        idle(T - 1);
        send(8'h72);
        checks++;
        if ({key_press, key_held} !== 8'b1000_1000) begin
            errors++;
            $display("FAIL tmo_edge got %b exp 10001000", {key_press, key_held});
        end
        // Timeout leaves held keys alone.
        send(8'hF0);
        idle(T + 2);
        checks++;
        if (key_held !== 4'b1000) begin
            errors++;
            $display("FAIL tmo_keeps_held got %b exp 1000", key_held);
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h72);
        checks++;
        if ({key_release, key_held} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL tmo_break_down got %b exp 10000000", {key_release, key_held});
        end
    endtask

    task automatic test_reset_mid();
        send(8'hF0);
        do_reset();
        send(8'h1D);
        checks++;
        if ({key_press, key_held} !== 8'b0001_0001) begin
            errors++;
            $display("FAIL reset_mid got %b exp 00010001", {key_press, key_held});
        end
    endtask

    task automatic test_back_to_back();
        kb_data  = 8'h1B;
        kb_valid = 1'b1;
        @(negedge clk50);
        checks++;
        if ({key_press, key_held} !== 8'b0010_0011) begin
            errors++;
            $display("FAIL b2b_first got %b exp 00100011", {key_press, key_held});
        end
        kb_data = 8'hF0;
        @(negedge clk50);
        kb_data = 8'h1D;
        @(negedge clk50);
        kb_valid = 1'b0;
        checks++;
        if ({key_release, key_held} !== 8'b0001_0010) begin
            errors++;
            $display("FAIL b2b_break got %b exp 00010010", {key_release, key_held});
        end
        do_reset();
        checks++;
        if (key_held !== 4'b0000) begin
            errors++;
            $display("FAIL final_reset got %b exp 0000", key_held);
        end
    endtask

    initial begin
        @(negedge clk50);
        test_reset();
        test_make_break();
        test_typematic();
        test_unmatched();
        test_error();
        test_pause();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Converts the PS/2 scancode byte stream from the keyboard receiver into per-key held state for up to N_KEYS configurable game keys.
- Outputs one-cycle press and release pulses per key.
- Decodes the set-2 prefixes E0 (extended) and F0 (break) itself, suppresses typematic repeat, skips the E1 Pause sequence, and clears all keys on keyboard error codes.
- Sits between the PS/2 receiver and the paddle/game logic; replaces the single make/break flag with a multi-key generalisation.

Parameters:
- N_KEYS, 4, number of tracked keys (1..16).
- KEY_CODES, {9'h172,9'h175,9'h01B,9'h01D}, packed N_KEYS x 9 bits. Entry i is bits [9i+8:9i]. Bit 8 = extended (E0) key, bits 7:0 = scancode. Default order, index 0..3: W 0x1D, S 0x1B, Up E0 75, Down E0 72.
- TIMEOUT, 50000, clock cycles a pending prefix survives without a new byte (1 ms at 50 MHz).

Ports:
- clk50, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- kb_data, input, 8, received scancode byte.
- kb_valid, input, 1, one-cycle strobe; kb_data is valid this cycle.
- key_held, output, N_KEYS, level; bit i = key i currently down.
- key_press, output, N_KEYS, one-cycle pulse on first make of key i.
- key_release, output, N_KEYS, one-cycle pulse on break of a held key i.
- kb_error, output, 1, one-cycle pulse when an error/BAT byte clears state.

Behaviour:
- Reset: key_held = 0, key_press = 0, key_release = 0, kb_error = 0, FSM = IDLE, timeout counter = 0, skip counter = 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0), SKIP (E1 sequence).
- Transitions on a kb_valid byte b:
  - IDLE: b=E0 -> EXT; b=F0 -> BRK; b=E1 -> SKIP with skip count 7; otherwise make {0,b}, stay IDLE.
  - EXT: b=F0 -> EXT_BRK; b=E0 -> EXT; otherwise make {1,b} -> IDLE.
  - BRK: break {0,b} -> IDLE.
  - EXT_BRK: break {1,b} -> IDLE.
  - SKIP: decrement skip count per byte; at 0 -> IDLE. No key effect.
- Error bytes 0x00, 0xFF, 0xFE, 0xAA in any state except SKIP:
  - key_held <= 0; no press/release pulses.
  - kb_error pulses; FSM -> IDLE.
  - An error byte has priority over prefix decoding.
- Make of code c: for every i with KEY_CODES[i]==c:
  - If key_held[i]=0: set held, pulse key_press[i].
  - If already held (typematic repeat): no pulse.
- Break of code c: for matching i with held=1, clear held and pulse key_release[i]. Break of an unheld key has no effect.
- Duplicate entries in KEY_CODES are legal; all matching bits act together. Unmatched codes are ignored.
- Latency: held, press and release update on the clock edge that samples kb_valid. Outputs are visible the following cycle. Pulses are exactly 1 cycle.
- Timeout:
  - Counter runs while FSM is not IDLE and kb_valid=0; it resets to 0 on any kb_valid.
  - On reaching TIMEOUT-1, FSM -> IDLE and the skip count is cleared; key_held is unchanged.
  - If kb_valid arrives in the cycle the counter would expire, the byte is decoded in the current state and the timeout does not fire.
- Reset mid-sequence: prefix state is discarded; a following byte that completes the sequence is decoded from IDLE (e.g. a trailing 1D after F0 becomes a make).
- All pulse outputs are registered; no combinational path from input to output.

Test Plan:
- Byte 1D -> key_press[0] pulses 1 cycle, key_held=4'b0001. Then F0,1D -> key_release[0] pulses, key_held=4'b0000.
- 1D,1D,1D (typematic) -> exactly one key_press[0] pulse, held stays 4'b0001. E0,75 -> key_press[2], held=4'b0101. E0,F0,75 -> key_release[2], held=4'b0001.
- Byte 75 without E0 -> no effect, held unchanged. F0,72 (break of Down without E0) -> no effect.
- Hold W and Down (held=4'b1001), then byte AA -> kb_error 1 cycle, held=0, no release pulses.
- E1,14,77,E1,F0,14,F0,77 -> no pulses, FSM back in IDLE. Next byte 1B -> key_press[1].
- E0, then TIMEOUT idle cycles, then 72 -> treated as non-extended 0x072, no effect. Repeat with 72 arriving at cycle TIMEOUT-1 -> key_press[3]. Assert reset between F0 and 1D -> 1D decoded as a make.
